// File: rtl/dec4_to_16_pkg.sv
// dec4_to_16_pkg: shared widths and types for the registered 4-to-16 decoder.
// Optional one-hot checker is enabled by defining DEC4_TO_16_ONEHOT_CHK_EN.
package dec4_to_16_pkg;
  localparam int DEC_IN_W  = 4;
  localparam int DEC_OUT_W = 16;
  localparam int DEC_GRP_W = 2;

  typedef logic [DEC_IN_W-1:0]  dec_sel_t;
  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

  // True when v has zero or one bit set (v & (v-1) clears the lowest set bit).
  function automatic logic onehot0(input dec_onehot_t v);
    return ((v & (v - dec_onehot_t'(1))) == '0);
  endfunction
endpackage

// File: rtl/dec4_to_16_if.sv
// dec4_to_16_if: select/enable request and decoded strobe response bundle.
// The err flag exists only when DEC4_TO_16_ONEHOT_CHK_EN is defined.
interface dec4_to_16_if;
  import dec4_to_16_pkg::*;

  dec_sel_t    w;
  logic        en;
  dec_onehot_t y;
  logic        active;
`ifdef DEC4_TO_16_ONEHOT_CHK_EN
  logic        err;
`endif

`ifdef DEC4_TO_16_ONEHOT_CHK_EN
  modport master (output w, en, input y, active, err);
  modport slave  (input w, en, output y, active, err);
`else
  modport master (output w, en, input y, active);
  modport slave  (input w, en, output y, active);
`endif
endinterface

// File: rtl/dec4_to_16_dec2to4.sv
// dec2to4: combinational 2-to-4 one-hot decoder with enable.
// An AND with en keeps outputs 0 when disabled, even if w is unknown.
module dec2to4 (
  input  logic [1:0] w,
  input  logic       en,
  output logic [3:0] y
);
  for (genvar k = 0; k < 4; k++) begin : g_bit
    assign y[k] = en & (w == 2'(k));
  end
endmodule

// File: rtl/dec4_to_16.sv
// dec4_to_16: registered 4-to-16 one-hot decoder built as a 2-level tree.
// Define DEC4_TO_16_ONEHOT_CHK_EN to add the sticky one-hot checker (err).
module dec4_to_16
  import dec4_to_16_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  dec4_to_16_if.slave  bus
);
  localparam int NGRP = DEC_OUT_W / (1 << DEC_GRP_W);

  logic [NGRP-1:0] grp_en;
  dec_onehot_t     y_next;
  dec_onehot_t     y_q;
  logic            active_q;

  // Upper stage: w[3:2] gated by en selects one group.
  dec2to4 u_upper (
    .w  (bus.w[DEC_IN_W-1:DEC_GRP_W]),
    .en (bus.en),
    .y  (grp_en)
  );

  // Lower stage: each group decodes w[1:0] into its 4 output bits.
  for (genvar g = 0; g < NGRP; g++) begin : g_lower
    dec2to4 u_lower (
      .w  (bus.w[DEC_GRP_W-1:0]),
      .en (grp_en[g]),
      .y  (y_next[4*g +: 4])
    );
  end

  // Output registers; reset clears any decode in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      active_q <= 1'b0;
    end else begin
      y_q      <= y_next;
      active_q <= bus.en;
    end
  end

  assign bus.y      = y_q;
  assign bus.active = active_q;

`ifdef DEC4_TO_16_ONEHOT_CHK_EN
  logic err_q;
  logic bad;

  assign bad = !onehot0(y_q) || ((|y_q) != active_q);

  // Sticky flag raised the cycle after the registered outputs look inconsistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | bad;
  end

  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_dec4_to_16.sv
// tb_dec4_to_16: directed + random scoreboard bench for dec4_to_16.
// Checks err as well when DEC4_TO_16_ONEHOT_CHK_EN is defined.
module tb_dec4_to_16;
  import dec4_to_16_pkg::*;

  typedef struct {
    dec_onehot_t y;
    logic        act;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  dec4_to_16_if bus ();

  dec4_to_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at negedge, push reference, compare after the next posedge.
  task automatic step(input string tag, input logic [3:0] w, input logic en);
    exp_t e;
    @(negedge clk);
    bus.w  = w;
    bus.en = en;
    e.y   = (en === 1'b1) ? (dec_onehot_t'(1) << w) : '0;
    e.act = (en === 1'b1);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_y"}, 32'(bus.y), 32'(e.y));
      check({e.tag, "_act"}, 32'(bus.active), 32'(e.act));
    end
  endtask

  initial begin
    logic [3:0] rw;
    logic       ren;
    bus.w  = 4'h5;
    bus.en = 1'b1;

    // Reset held with a live code on the inputs.
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", 32'(bus.y), 32'h0);
    check("rst_act", 32'(bus.active), 32'h0);
`ifdef DEC4_TO_16_ONEHOT_CHK_EN
    check("rst_err", 32'(bus.err), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 4'h5, 1'b1);
    check("post_rst_val", 32'(bus.y), 32'h0020);

    step("disabled", 4'h0, 1'b0);

    for (int i = 0; i < 16; i++) step($sformatf("sweep%0d", i), 4'(i), 1'b1);
    check("sweep_last", 32'(bus.y), 32'h8000);

    step("dis_mid", 4'b1010, 1'b0);
    check("dis_mid_b10", 32'(bus.y[10]), 32'h0);

    // Unknown select while disabled must not leak X.
    @(negedge clk);
    bus.w  = 4'bxxxx;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("x_y", 32'(bus.y), 32'h0);
    check("x_act", 32'(bus.active), 32'h0);
    check("x_known", 32'($isunknown({bus.y, bus.active})), 32'h0);

    // Asynchronous reset mid-operation discards the in-flight decode.
    step("pre_arst", 4'h3, 1'b1);
    @(negedge clk);
    bus.w  = 4'h9;
    bus.en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y", 32'(bus.y), 32'h0);
    check("arst_act", 32'(bus.active), 32'h0);
    @(posedge clk);
    #1;
    check("arst_hold", 32'(bus.y), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("arst_rel", 4'h5, 1'b1);

    // Random stream: one-hot-or-zero and consistency with active every cycle.
    for (int i = 0; i < 1000; i++) begin
      rw  = 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 3) != 0);
      step("rnd", rw, ren);
      check("rnd_oh", 32'(onehot0(bus.y)), 32'h1);
`ifdef DEC4_TO_16_ONEHOT_CHK_EN
      check("rnd_err", 32'(bus.err), 32'h0);
`endif
    end

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
